// File: rtl/bht_sram_bist_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | bht_sram_bist_ctrl: March C- BIST sequencer and port mux for the BHT array. |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module bht_sram_bist_ctrl #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  forever_cpuclk,
  input  logic                  bist_rst,
  input  logic                  bist_start,
  input  logic [ADDR_WIDTH-1:0] func_idx,
  input  logic [DATA_WIDTH-1:0] func_din,
  input  logic                  func_cen,
  input  logic                  func_gwen,
  input  logic [DATA_WIDTH-1:0] func_wen,
  input  logic [DATA_WIDTH-1:0] sram_q,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic [DATA_WIDTH-1:0] sram_d,
  output logic                  sram_cen,
  output logic                  sram_gwen,
  output logic [DATA_WIDTH-1:0] sram_wen,
  output logic                  bist_busy,
  output logic                  bist_done,
  output logic                  bist_fail,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [2:0]            fail_elem,
  output logic [DATA_WIDTH-1:0] fail_exp,
  output logic [DATA_WIDTH-1:0] fail_data
);

  function automatic logic [DATA_WIDTH-1:0] odd_bits();
    logic [DATA_WIDTH-1:0] m;
    m = '0;
    for (int i = 1; i < DATA_WIDTH; i += 2) m[i] = 1'b1;
    return m;
  endfunction

  localparam logic [DATA_WIDTH-1:0] C_ONES     = '1;
  localparam logic [DATA_WIDTH-1:0] C_ODD_BITS = odd_bits();
  localparam logic [ADDR_WIDTH-1:0] C_ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RUN      = 2'd1,
    S_CHK_TAIL = 2'd2,
    S_DONE     = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [2:0]              elem_q, elem_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    phase_q, phase_d;
  logic                    rd_vld_q, rd_vld_d;
  logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
  logic [2:0]              rd_elem_q, rd_elem_d;
  logic [DATA_WIDTH-1:0]   rd_exp_q, rd_exp_d;
  logic                    fail_q, fail_d;
  logic [ADDR_WIDTH-1:0]   fail_addr_q, fail_addr_d;
  logic [2:0]              fail_elem_q, fail_elem_d;
  logic [DATA_WIDTH-1:0]   fail_exp_q, fail_exp_d;
  logic [DATA_WIDTH-1:0]   fail_data_q, fail_data_d;

  // Per-element op decode; phase 0 of a two-op element is always the read.
  logic                  op_rd, op_two, op_down;
  logic [DATA_WIDTH-1:0] op_data, op_wen, op_exp;

  always_comb begin
    op_rd   = 1'b0;
    op_two  = 1'b0;
    op_down = 1'b0;
    op_data = '0;
    op_wen  = '0;
    op_exp  = '0;
    case (elem_q)
      3'd0: op_data = '0;
      3'd1: begin op_two = 1'b1; op_rd = ~phase_q; op_data = C_ONES; op_exp = '0; end
      3'd2: begin op_two = 1'b1; op_rd = ~phase_q; op_data = '0; op_exp = C_ONES; end
      3'd3: begin op_two = 1'b1; op_down = 1'b1; op_rd = ~phase_q; op_data = C_ONES; op_exp = '0; end
      3'd4: begin op_two = 1'b1; op_down = 1'b1; op_rd = ~phase_q; op_data = '0; op_exp = C_ONES; end
      3'd5: begin op_down = 1'b1; op_rd = 1'b1; op_exp = '0; end
      3'd6: begin op_data = C_ONES; op_wen = C_ODD_BITS; end
      default: begin op_rd = 1'b1; op_exp = ~C_ODD_BITS; end
    endcase
  end

  logic at_elem_end;
  logic next_down;
  logic cmp_miss;

  assign at_elem_end = op_down ? (addr_q == '0) : (addr_q == '1);
  assign next_down   = (elem_q == 3'd2) || (elem_q == 3'd3) || (elem_q == 3'd4);
  assign cmp_miss    = rd_vld_q && ((state_q == S_RUN) || (state_q == S_CHK_TAIL))
                       && (sram_q != rd_exp_q);

  always_comb begin
    state_d     = state_q;
    elem_d      = elem_q;
    addr_d      = addr_q;
    phase_d     = phase_q;
    rd_vld_d    = 1'b0;
    rd_addr_d   = rd_addr_q;
    rd_elem_d   = rd_elem_q;
    rd_exp_d    = rd_exp_q;
    fail_d      = fail_q;
    fail_addr_d = fail_addr_q;
    fail_elem_d = fail_elem_q;
    fail_exp_d  = fail_exp_q;
    fail_data_d = fail_data_q;

    case (state_q)
      S_IDLE: begin
        if (bist_start) begin
          state_d     = S_RUN;
          elem_d      = 3'd0;
          addr_d      = '0;
          phase_d     = 1'b0;
          fail_d      = 1'b0;
          fail_addr_d = '0;
          fail_elem_d = 3'd0;
          fail_exp_d  = '0;
          fail_data_d = '0;
        end
      end
      S_RUN: begin
        rd_vld_d  = op_rd;
        rd_addr_d = addr_q;
        rd_elem_d = elem_q;
        rd_exp_d  = op_exp;
        if (op_two && !phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          if (at_elem_end) begin
            elem_d = elem_q + 3'd1;
            addr_d = next_down ? '1 : '0;
            if (elem_q == 3'd7) state_d = S_CHK_TAIL;
          end else begin
            addr_d = op_down ? (addr_q - C_ADDR_ONE) : (addr_q + C_ADDR_ONE);
          end
        end
        if (cmp_miss) state_d = S_DONE;
      end
      S_CHK_TAIL: state_d = S_DONE;
      default:    state_d = S_IDLE;
    endcase

    // Only the first mismatch of a run is captured.
    if (cmp_miss && !fail_q) begin
      fail_d      = 1'b1;
      fail_addr_d = rd_addr_q;
      fail_elem_d = rd_elem_q;
      fail_exp_d  = rd_exp_q;
      fail_data_d = sram_q;
    end
  end

  always_ff @(posedge forever_cpuclk) begin
    if (bist_rst) begin
      state_q     <= S_IDLE;
      elem_q      <= 3'd0;
      addr_q      <= '0;
      phase_q     <= 1'b0;
      rd_vld_q    <= 1'b0;
      rd_addr_q   <= '0;
      rd_elem_q   <= 3'd0;
      rd_exp_q    <= '0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_elem_q <= 3'd0;
      fail_exp_q  <= '0;
      fail_data_q <= '0;
    end else begin
      state_q     <= state_d;
      elem_q      <= elem_d;
      addr_q      <= addr_d;
      phase_q     <= phase_d;
      rd_vld_q    <= rd_vld_d;
      rd_addr_q   <= rd_addr_d;
      rd_elem_q   <= rd_elem_d;
      rd_exp_q    <= rd_exp_d;
      fail_q      <= fail_d;
      fail_addr_q <= fail_addr_d;
      fail_elem_q <= fail_elem_d;
      fail_exp_q  <= fail_exp_d;
      fail_data_q <= fail_data_d;
    end
  end

  // Array port mux; CHK_TAIL keeps the array idle while the last read is compared.
  always_comb begin
    sram_a    = func_idx;
    sram_d    = func_din;
    sram_cen  = func_cen;
    sram_gwen = func_gwen;
    sram_wen  = func_wen;
    if (state_q == S_RUN) begin
      sram_a    = addr_q;
      sram_d    = op_rd ? '0 : op_data;
      sram_cen  = 1'b0;
      sram_gwen = op_rd;
      sram_wen  = op_rd ? C_ONES : op_wen;
    end else if (state_q == S_CHK_TAIL) begin
      sram_a    = '0;
      sram_d    = '0;
      sram_cen  = 1'b1;
      sram_gwen = 1'b1;
      sram_wen  = C_ONES;
    end
    if (bist_rst) sram_cen = 1'b1;
  end

  assign bist_busy = (state_q == S_RUN) || (state_q == S_CHK_TAIL);
  assign bist_done = (state_q == S_DONE);
  assign bist_fail = fail_q;
  assign fail_addr = fail_addr_q;
  assign fail_elem = fail_elem_q;
  assign fail_exp  = fail_exp_q;
  assign fail_data = fail_data_q;

endmodule
`default_nettype wire

// File: tb/tb_bht_sram_bist_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_bht_sram_bist_ctrl: directed bench with a behavioural array model.       |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module tb_bht_sram_bist_ctrl;

  localparam int AW = 7;
  localparam int DW = 16;
  localparam int N  = 1 << AW;

  logic          clk = 1'b0;
  logic          bist_rst = 1'b1;
  logic          bist_start = 1'b0;
  logic [AW-1:0] func_idx = '0;
  logic [DW-1:0] func_din = '0;
  logic          func_cen = 1'b0;
  logic          func_gwen = 1'b1;
  logic [DW-1:0] func_wen = '1;
  logic [DW-1:0] sram_q;
  logic [AW-1:0] sram_a;
  logic [DW-1:0] sram_d;
  logic          sram_cen, sram_gwen;
  logic [DW-1:0] sram_wen;
  logic          bist_busy, bist_done, bist_fail;
  logic [AW-1:0] fail_addr;
  logic [2:0]    fail_elem;
  logic [DW-1:0] fail_exp, fail_data;

  int checks = 0;
  int errors = 0;
  int fault_mode = 0;  // 0 ideal, 1 bit3 stuck-at-1 at addr 5, 2 WEN ignored

  always #5 clk = ~clk;

  bht_sram_bist_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .forever_cpuclk(clk), .bist_rst(bist_rst), .bist_start(bist_start),
    .func_idx(func_idx), .func_din(func_din), .func_cen(func_cen),
    .func_gwen(func_gwen), .func_wen(func_wen), .sram_q(sram_q),
    .sram_a(sram_a), .sram_d(sram_d), .sram_cen(sram_cen),
    .sram_gwen(sram_gwen), .sram_wen(sram_wen), .bist_busy(bist_busy),
    .bist_done(bist_done), .bist_fail(bist_fail), .fail_addr(fail_addr),
    .fail_elem(fail_elem), .fail_exp(fail_exp), .fail_data(fail_data)
  );

  // Single-port array model with 1-cycle read latency.
  logic [DW-1:0] mem [N];
  logic [DW-1:0] q_r = '0;
  assign sram_q = q_r;

  initial for (int i = 0; i < N; i++) mem[i] = '0;

  always @(posedge clk) begin
    if (!sram_cen) begin
      if (!sram_gwen) begin
        for (int b = 0; b < DW; b++)
          if (!sram_wen[b] || fault_mode == 2) mem[sram_a][b] <= sram_d[b];
      end else begin
        q_r <= mem[sram_a] | ((fault_mode == 1 && sram_a == 7'd5) ? 16'h0008 : 16'h0000);
      end
    end
  end

  // Run monitor: busy/done cycle counts and op-stream observations per run.
  int            busy_cnt = 0;
  int            done_cnt = 0;
  int            op_cnt = 0;
  int            first_bad = 0;
  logic [AW-1:0] e3_addr = '0;
  logic          e3_rd = 1'b0;
  logic          prev_busy = 1'b0;

  always @(negedge clk) begin
    if (bist_busy && !prev_busy) begin
      op_cnt    = 0;
      first_bad = 0;
    end
    if (bist_busy) busy_cnt++;
    if (bist_done) done_cnt++;
    if (bist_busy && !sram_cen) begin
      if (op_cnt < N && (sram_gwen !== 1'b0 || sram_a !== op_cnt[AW-1:0] ||
                         sram_d !== 16'h0000 || sram_wen !== 16'h0000))
        first_bad++;
      if (op_cnt == 5 * N) begin
        e3_addr = sram_a;
        e3_rd   = sram_gwen;
      end
      op_cnt++;
    end
    prev_busy = bist_busy;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    bist_start = 1'b1;
    tick();
    bist_start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      tick();
      if (bist_done) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL %s_done_timeout got=0 exp=1", tag); end
  endtask

  task automatic test_reset();
    bist_rst = 1'b1; func_cen = 1'b0;
    tick(); tick();
    checks++; if (sram_cen !== 1'b1) begin errors++; $display("FAIL rst_cen got=%b exp=1", sram_cen); end
    checks++; if ({bist_busy, bist_done, bist_fail} !== 3'b000) begin errors++; $display("FAIL rst_status got=%b exp=000", {bist_busy, bist_done, bist_fail}); end
    checks++; if ({fail_addr, fail_elem, fail_exp, fail_data} !== '0) begin errors++; $display("FAIL rst_fields got=%h exp=0", {fail_addr, fail_elem, fail_exp, fail_data}); end
    bist_rst = 1'b0; func_cen = 1'b1;
    tick();
  endtask

  task automatic test_pass(input string tag);
    int b0, d0;
    b0 = busy_cnt; d0 = done_cnt;
    pulse_start();
    checks++; if (bist_busy !== 1'b1) begin errors++; $display("FAIL %s_busy_rise got=%b exp=1", tag, bist_busy); end
    wait_done(tag);
    checks++; if (bist_busy !== 1'b0) begin errors++; $display("FAIL %s_busy_in_done got=%b exp=0", tag, bist_busy); end
    tick();
    checks++; if (busy_cnt - b0 != 12 * N + 1) begin errors++; $display("FAIL %s_busy_len got=%0d exp=%0d", tag, busy_cnt - b0, 12 * N + 1); end
    checks++; if (done_cnt - d0 != 1 || bist_done !== 1'b0) begin errors++; $display("FAIL %s_done_pulse got=%0d exp=1", tag, done_cnt - d0); end
    checks++; if (bist_fail !== 1'b0) begin errors++; $display("FAIL %s_fail got=%b exp=0", tag, bist_fail); end
    checks++; if (op_cnt != 12 * N) begin errors++; $display("FAIL %s_op_count got=%0d exp=%0d", tag, op_cnt, 12 * N); end
  endtask

  task automatic test_sequence_order();
    checks++; if (first_bad != 0) begin errors++; $display("FAIL seq_e0_writes got=%0d bad exp=0", first_bad); end
    checks++; if (e3_addr !== 7'd127 || e3_rd !== 1'b1) begin errors++; $display("FAIL seq_e3_start got=%0d/%b exp=127/1", e3_addr, e3_rd); end
  endtask

  task automatic test_passthrough();
    func_idx = 7'd9; func_din = 16'h1234; func_cen = 1'b0; func_gwen = 1'b0; func_wen = 16'h0000;
    #1;
    checks++; if ({sram_a, sram_d, sram_cen, sram_gwen, sram_wen} !== {7'd9, 16'h1234, 1'b0, 1'b0, 16'h0000}) begin
      errors++; $display("FAIL pt_mirror got=%h/%h/%b/%b/%h exp=09/1234/0/0/0000", sram_a, sram_d, sram_cen, sram_gwen, sram_wen); end
    tick();
    func_gwen = 1'b1; func_wen = 16'hFFFF; func_din = 16'h0000;
    tick();
    checks++; if (sram_q !== 16'h1234) begin errors++; $display("FAIL pt_readback got=%h exp=1234", sram_q); end
    func_cen = 1'b1;
    tick();
  endtask

  task automatic test_stuck_bit();
    fault_mode = 1;
    pulse_start();
    wait_done("stuck");
    checks++; if (bist_fail !== 1'b1) begin errors++; $display("FAIL stuck_fail got=%b exp=1", bist_fail); end
    checks++; if (fail_elem !== 3'd1 || fail_addr !== 7'd5) begin errors++; $display("FAIL stuck_loc got=%0d/%0d exp=1/5", fail_elem, fail_addr); end
    checks++; if (fail_exp !== 16'h0000 || fail_data !== 16'h0008) begin errors++; $display("FAIL stuck_data got=%h/%h exp=0000/0008", fail_exp, fail_data); end
    checks++; if (sram_cen !== 1'b1) begin errors++; $display("FAIL stuck_cen got=%b exp=1", sram_cen); end
    tick();
    checks++; if (op_cnt != 140) begin errors++; $display("FAIL stuck_abort_ops got=%0d exp=140", op_cnt); end
    fault_mode = 0;
  endtask

  task automatic test_fail_clear();
    pulse_start();
    checks++; if (bist_busy !== 1'b1 || bist_fail !== 1'b0) begin errors++; $display("FAIL clear_on_start got=%b/%b exp=1/0", bist_busy, bist_fail); end
    checks++; if ({fail_addr, fail_elem, fail_exp, fail_data} !== '0) begin errors++; $display("FAIL clear_fields got=%h exp=0", {fail_addr, fail_elem, fail_exp, fail_data}); end
    wait_done("clear");
    tick();
    checks++; if (bist_fail !== 1'b0) begin errors++; $display("FAIL clear_run_fail got=%b exp=0", bist_fail); end
  endtask

  task automatic test_wen_fault();
    fault_mode = 2;
    pulse_start();
    wait_done("wen");
    checks++; if (bist_fail !== 1'b1 || fail_elem !== 3'd7 || fail_addr !== 7'd0) begin errors++; $display("FAIL wen_loc got=%b/%0d/%0d exp=1/7/0", bist_fail, fail_elem, fail_addr); end
    checks++; if (fail_exp !== 16'h5555 || fail_data !== 16'hFFFF) begin errors++; $display("FAIL wen_data got=%h/%h exp=5555/ffff", fail_exp, fail_data); end
    tick();
    checks++; if (op_cnt != 11 * N + 2) begin errors++; $display("FAIL wen_abort_ops got=%0d exp=%0d", op_cnt, 11 * N + 2); end
    fault_mode = 0;
  endtask

  task automatic test_reset_midrun();
    pulse_start();
    repeat (299) tick();
    bist_rst = 1'b1; func_cen = 1'b0;
    tick();
    checks++; if ({bist_busy, bist_done, bist_fail, sram_cen} !== 4'b0001) begin errors++; $display("FAIL midrst_state got=%b exp=0001", {bist_busy, bist_done, bist_fail, sram_cen}); end
    bist_start = 1'b1;
    tick();
    bist_start = 1'b0;
    checks++; if (bist_busy !== 1'b0 || sram_cen !== 1'b1) begin errors++; $display("FAIL midrst_start_vs_rst got=%b/%b exp=0/1", bist_busy, sram_cen); end
    bist_rst = 1'b0; func_cen = 1'b1;
    tick();
    test_pass("after_rst");
  endtask

  task automatic test_back_to_back();
    int b0, d0;
    b0 = busy_cnt; d0 = done_cnt;
    pulse_start();
    func_idx = 7'd9; func_din = 16'hFFFF; func_cen = 1'b0; func_gwen = 1'b1; func_wen = 16'hFFFF;
    repeat (3) tick();
    checks++; if ({sram_a, sram_gwen, sram_d, sram_wen, sram_cen} !== {7'd3, 1'b0, 16'h0000, 16'h0000, 1'b0}) begin
      errors++; $display("FAIL busy_ignores_func got=%h/%b/%h/%h/%b exp=03/0/0000/0000/0", sram_a, sram_gwen, sram_d, sram_wen, sram_cen); end
    repeat (10) tick();
    pulse_start();
    func_cen = 1'b1; func_gwen = 1'b1;
    wait_done("b2b");
    tick();
    checks++; if (busy_cnt - b0 != 12 * N + 1 || done_cnt - d0 != 1) begin errors++; $display("FAIL b2b_no_restart got=%0d/%0d exp=%0d/1", busy_cnt - b0, done_cnt - d0, 12 * N + 1); end
    checks++; if (bist_fail !== 1'b0) begin errors++; $display("FAIL b2b_fail got=%b exp=0", bist_fail); end
  endtask

  initial begin
    test_reset();
    test_pass("pass");
    test_sequence_order();
    test_passthrough();
    test_stuck_bit();
    test_fail_clear();
    test_wen_fault();
    test_reset_midrun();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
